vga_timing_gen: RTL

//  Parametrised VGA raster timing generator; supersedes the separate H/V counters.

---
 rtl/vga_timing_pkg.sv | 32 +++
 rtl/vga_timing_gen_if.sv | 25 ++
 rtl/vga_axis_ctr.sv | 74 +++++++
 rtl/vga_timing_gen.sv | 106 ++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared defaults, the raster bus struct and the total-length helper for the
// VGA timing generator and its per-axis counters.
package vga_timing_pkg;

    // 800x600@60 Hz (40 MHz dot clock)
    localparam int VGA_CNT_W    = 11;
    localparam int VGA_H_ACTIVE = 800;
    localparam int VGA_H_FP     = 40;
    localparam int VGA_H_SYNC   = 128;
    localparam int VGA_H_BP     = 88;
    localparam int VGA_V_ACTIVE = 600;
    localparam int VGA_V_FP     = 1;
    localparam int VGA_V_SYNC   = 4;
    localparam int VGA_V_BP     = 23;
    localparam logic VGA_HS_POL = 1'b1;
    localparam logic VGA_VS_POL = 1'b1;

    typedef struct packed {
        logic [VGA_CNT_W-1:0] hcount;
        logic [VGA_CNT_W-1:0] vcount;
        logic                 hsync;
        logic                 vsync;
        logic                 hblnk;
        logic                 vblnk;
    } vga_timing_t;

    function automatic int calc_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bus: the generator drives position, sync, blank and strobes;
// the draw pipeline supplies the pixel enable.
interface vga_timing_gen_if #(
    parameter int CNT_W = 11
);
    logic             pix_en;
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
    logic             line_start;
    logic             frame_start;

    modport master (
        input  pix_en,
        output hcount, vcount, hsync, vsync, hblnk, vblnk, line_start, frame_start
    );

    modport slave (
        output pix_en,
        input  hcount, vcount, hsync, vsync, hblnk, vblnk, line_start, frame_start
    );
endinterface

// File: rtl/vga_axis_ctr.sv
// One raster axis: wrapping position counter with registered sync/blank decoded
// from the next count, so all outputs change on the same edge as the count.
module vga_axis_ctr
    import vga_timing_pkg::*;
#(
    parameter int   CNT_W  = 11,
    parameter int   ACTIVE = 800,
    parameter int   FP     = 40,
    parameter int   SYNC   = 128,
    parameter int   BP     = 88,
    parameter logic POL    = 1'b1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             i_step,
    output logic [CNT_W-1:0] o_count,
    output logic             o_sync,
    output logic             o_blnk,
    output logic             o_wrap
);

    localparam int TOTAL    = calc_total(ACTIVE, FP, SYNC, BP);
    localparam int SYNC_BEG = ACTIVE + FP;
    localparam int SYNC_END = ACTIVE + FP + SYNC;

    localparam logic [CNT_W-1:0] C_LAST     = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] C_ACTIVE   = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] C_SYNC_BEG = CNT_W'(SYNC_BEG);
    localparam logic [CNT_W-1:0] C_SYNC_END = CNT_W'(SYNC_END);

    logic [CNT_W-1:0] r_count;
    logic             r_sync;
    logic             r_blnk;

    logic [CNT_W-1:0] w_count_next;
    logic             w_sync_next;
    logic             w_blnk_next;
    logic             w_sync_act;
    logic             w_wrap;

    assign w_wrap = i_step && (r_count == C_LAST);

    always_comb begin
        w_count_next = r_count;
        if (i_step) begin
            w_count_next = w_wrap ? '0 : r_count + 1'b1;
        end
    end

    // Decoding the next value keeps sync/blank on the same edge as the count.
    always_comb begin
        w_blnk_next = (w_count_next >= C_ACTIVE);
        w_sync_act  = (w_count_next >= C_SYNC_BEG) && (w_count_next < C_SYNC_END);
        w_sync_next = w_sync_act ? POL : ~POL;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_count <= '0;
            r_sync  <= ~POL;
            r_blnk  <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_sync  <= w_sync_next;
            r_blnk  <= w_blnk_next;
        end
    end

    assign o_count = r_count;
    assign o_sync  = r_sync;
    assign o_blnk  = r_blnk;
    assign o_wrap  = w_wrap;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: horizontal and vertical axis
// counters plus registered line/frame start strobes.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   CNT_W    = VGA_CNT_W,
    parameter int   H_ACTIVE = VGA_H_ACTIVE,
    parameter int   H_FP     = VGA_H_FP,
    parameter int   H_SYNC   = VGA_H_SYNC,
    parameter int   H_BP     = VGA_H_BP,
    parameter int   V_ACTIVE = VGA_V_ACTIVE,
    parameter int   V_FP     = VGA_V_FP,
    parameter int   V_SYNC   = VGA_V_SYNC,
    parameter int   V_BP     = VGA_V_BP,
    parameter logic HS_POL   = VGA_HS_POL,
    parameter logic VS_POL   = VGA_VS_POL
) (
    input  logic                pclk,
    input  logic                rst,
    vga_timing_gen_if.master    tmg
);

    localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (CNT_W <= 0 || CNT_W > 30) begin : g_bad_cnt_w
        $error("vga_timing_gen: CNT_W out of range");
    end

    if (H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
        V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0) begin : g_bad_param
        $error("vga_timing_gen: timing parameters must be non-zero");
    end

    if (H_TOTAL > 2**CNT_W || V_TOTAL > 2**CNT_W) begin : g_bad_total
        $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
    end

    logic [CNT_W-1:0] w_hcount;
    logic [CNT_W-1:0] w_vcount;
    logic             w_hsync;
    logic             w_vsync;
    logic             w_hblnk;
    logic             w_vblnk;
    logic             w_h_wrap;
    logic             w_v_wrap;

    logic             r_line_start;
    logic             r_frame_start;

    vga_axis_ctr #(
        .CNT_W  (CNT_W),
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (HS_POL)
    ) u_h_ctr (
        .clk     (pclk),
        .srst    (rst),
        .i_step  (tmg.pix_en),
        .o_count (w_hcount),
        .o_sync  (w_hsync),
        .o_blnk  (w_hblnk),
        .o_wrap  (w_h_wrap)
    );

    // The vertical axis advances only on the enabled cycle that ends a line.
    vga_axis_ctr #(
        .CNT_W  (CNT_W),
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (VS_POL)
    ) u_v_ctr (
        .clk     (pclk),
        .srst    (rst),
        .i_step  (w_h_wrap),
        .o_count (w_vcount),
        .o_sync  (w_vsync),
        .o_blnk  (w_vblnk),
        .o_wrap  (w_v_wrap)
    );

    // Strobes are registered from the wrap so they land on the cycle the count reads 0.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= w_h_wrap;
            r_frame_start <= w_h_wrap && w_v_wrap;
        end
    end

    assign tmg.hcount      = w_hcount;
    assign tmg.vcount      = w_vcount;
    assign tmg.hsync       = w_hsync;
    assign tmg.vsync       = w_vsync;
    assign tmg.hblnk       = w_hblnk;
    assign tmg.vblnk       = w_vblnk;
    assign tmg.line_start  = r_line_start;
    assign tmg.frame_start = r_frame_start;

endmodule
